nn_layer_sequencer: RTL

Central control FSM for the two-layer MNIST classifier datapath (784→20→10). It steps the pixel address through one image, qualifies layer-1 MAC accumulation, and waits out the bias/ReLU pipeline. It then serialises the 20 hidden activations through the parallel-to-serial unit into the layer-2 MACs and fires the bias2 read and compare strobes. It is the single owner of every datapath control strobe and replaces free-running control.

---
 rtl/nn_layer_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
//
// Central control FSM for the two-layer MNIST classifier datapath
// (784 -> 20 -> 10). One inference walks the pixel address through the image
// while qualifying layer-1 MAC beats. It then waits out the bias/ReLU pipeline,
// parallel-loads the hidden activations into the parallel-to-serial unit and
// streams them into the layer-2 MACs. Finally it fires the bias2 read and the
// argmax compare strobes and pulses done.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        begin one inference (sampled only in IDLE)
//   abort        synchronous abort, back to IDLE on the next edge
//   pix_valid    pixel source presents the pixel at pixel_addr this cycle
//   pixel_addr   current pixel index (layer-1 beat counter)
//   l1_en        layer-1 accumulate qualifier (state==L1 && pix_valid)
//   begin_sign   clear layer-1 accumulators
//   finish_sign  layer-1 complete, latch MAC results
//   pts_load     parallel load of ReLU outputs into the pts unit
//   pts_out      pts shift-out enable
//   hid_addr     hidden index / layer-2 weight row address
//   weight2_rd   layer-2 weight memory read enable
//   mac2_en      layer-2 MAC accumulate enable
//   mac2_clr     layer-2 MAC clear
//   bias2_rd     bias2 memory read strobe
//   compare_en   argmax compare enable
//   busy         FSM is not in IDLE
//   done         one-cycle inference-complete pulse
//   state_dbg    current FSM state encoding (IDLE = 0), for debug/checkers
//
// Handshake: pix_valid is a one-sided valid. A layer-1 beat is consumed on a
// rising edge where state is L1 and pix_valid is 1. There is no ready back to
// the pixel source; the source must hold the pixel at pixel_addr until it is
// consumed, and pixel_addr only advances on a consumed beat.
// -----------------------------------------------------------------------------
module nn_layer_sequencer #(
  parameter int N_PIXELS = 784,
  parameter int N_HIDDEN = 20,
  parameter int L1_LAT   = 3,
  parameter int L2_LAT   = 1,
  parameter int B2_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pix_valid,
  output logic [9:0] pixel_addr,
  output logic       l1_en,
  output logic       begin_sign,
  output logic       finish_sign,
  output logic       pts_load,
  output logic       pts_out,
  output logic [4:0] hid_addr,
  output logic       weight2_rd,
  output logic       mac2_en,
  output logic       mac2_clr,
  output logic       bias2_rd,
  output logic       compare_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CLR     = 4'd1,
    S_L1      = 4'd2,
    S_L1_WAIT = 4'd3,
    S_LOAD    = 4'd4,
    S_L2      = 4'd5,
    S_L2_WAIT = 4'd6,
    S_BIAS2   = 4'd7,
    S_B2_WAIT = 4'd8,
    S_CMP     = 4'd9,
    S_DONE    = 4'd10
  } state_t;

  localparam logic [9:0] PIX_LAST = 10'(N_PIXELS - 1);
  localparam logic [4:0] HID_LAST = 5'(N_HIDDEN - 1);
  localparam logic [7:0] L1_LAST  = 8'(L1_LAT - 1);
  localparam logic [7:0] L2_LAST  = 8'(L2_LAT - 1);
  localparam logic [7:0] B2_LAST  = 8'(B2_LAT - 1);

  state_t     state;
  // Shared cycle counter for the three pipeline-wait states; it is always 0
  // on entry to a wait state so finish_sign can key off its first cycle.
  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state      <= S_IDLE;
      pixel_addr <= 10'd0;
      hid_addr   <= 5'd0;
      wait_cnt   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_CLR;
        end
        S_CLR: begin
          pixel_addr <= 10'd0;
          state      <= S_L1;
        end
        S_L1: begin
          // Stalls simply hold pixel_addr; the last beat returns it to 0.
          if (pix_valid) begin
            if (pixel_addr == PIX_LAST) begin
              pixel_addr <= 10'd0;
              wait_cnt   <= 8'd0;
              state      <= S_L1_WAIT;
            end else begin
              pixel_addr <= pixel_addr + 10'd1;
            end
          end
        end
        S_L1_WAIT: begin
          if (wait_cnt == L1_LAST) begin
            wait_cnt <= 8'd0;
            state    <= S_LOAD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_LOAD: begin
          hid_addr <= 5'd0;
          state    <= S_L2;
        end
        S_L2: begin
          // Layer 2 never stalls: one hidden activation per cycle.
          if (hid_addr == HID_LAST) begin
            hid_addr <= 5'd0;
            wait_cnt <= 8'd0;
            state    <= S_L2_WAIT;
          end else begin
            hid_addr <= hid_addr + 5'd1;
          end
        end
        S_L2_WAIT: begin
          if (wait_cnt == L2_LAST) begin
            wait_cnt <= 8'd0;
            state    <= S_BIAS2;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_BIAS2: begin
          wait_cnt <= 8'd0;
          state    <= S_B2_WAIT;
        end
        S_B2_WAIT: begin
          if (wait_cnt == B2_LAST) begin
            wait_cnt <= 8'd0;
            state    <= S_CMP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_CMP: begin
          state <= S_DONE;
        end
        S_DONE: begin
          // Always pass through IDLE, so back-to-back runs get a 1-cycle gap.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode of the registered state; l1_en is the only input-qualified
  // strobe because the MAC must not accumulate on a stalled pixel.
  assign l1_en       = (state == S_L1) && pix_valid;
  assign begin_sign  = (state == S_CLR);
  assign mac2_clr    = (state == S_CLR);
  assign finish_sign = (state == S_L1_WAIT) && (wait_cnt == 8'd0);
  assign pts_load    = (state == S_LOAD);
  assign pts_out     = (state == S_L2);
  assign weight2_rd  = (state == S_L2);
  assign mac2_en     = (state == S_L2);
  assign bias2_rd    = (state == S_BIAS2);
  assign compare_en  = (state == S_CMP);
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

endmodule
